// File: rtl/rs_station.sv
// rs_station -- reservation station feeding the integer execute unit.
// Holds issued ops until both operands are known, snooping the CDB for
// pending producer tags, and hands one ready op per cycle to execute.
// Optional macro RS_AGE_SELECT_EN: pick the oldest ready entry (age matrix)
// instead of the lowest-index ready entry.
module rs_station #(
   parameter int XLEN      = 32,
   parameter int TAG_WIDTH = 3,
   parameter int RS_DEPTH  = 4,
   parameter int OP_WIDTH  = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_i,
   input  logic                 flush_i,
   input  logic                 issue_en_i,
   input  logic [OP_WIDTH-1:0]  issue_op_i,
   input  logic                 rs1_valid_i,
   input  logic [XLEN-1:0]      rs1_value_i,
   input  logic [TAG_WIDTH-1:0] rs1_tag_i,
   input  logic                 rs2_valid_i,
   input  logic [XLEN-1:0]      rs2_value_i,
   input  logic [TAG_WIDTH-1:0] rs2_tag_i,
   input  logic [TAG_WIDTH-1:0] dest_tag_i,
   output logic                 full_o,
   input  logic                 cdb_valid_i,
   input  logic [TAG_WIDTH-1:0] cdb_tag_i,
   input  logic [XLEN-1:0]      cdb_value_i,
   output logic                 ex_valid_o,
   input  logic                 ex_ready_i,
   output logic [OP_WIDTH-1:0]  ex_op_o,
   output logic [XLEN-1:0]      ex_a_o,
   output logic [XLEN-1:0]      ex_b_o,
   output logic [TAG_WIDTH-1:0] ex_tag_o
);
   localparam int IW = $clog2(RS_DEPTH);

   logic [RS_DEPTH-1:0]                busy_q, busy_d, r1_q, r1_d, r2_q, r2_d;
   logic [RS_DEPTH-1:0][OP_WIDTH-1:0]  op_q, op_d;
   logic [RS_DEPTH-1:0][XLEN-1:0]      v1_q, v1_d, v2_q, v2_d;
   logic [RS_DEPTH-1:0][TAG_WIDTH-1:0] q1_q, q1_d, q2_q, q2_d, dest_q, dest_d;

   logic [RS_DEPTH-1:0] ready;
   logic [IW-1:0]       free_idx, sel_idx;
   logic                free_found, sel_found, accept, fire;

   assign ready      = busy_q & r1_q & r2_q;
   assign full_o     = &busy_q;
   assign accept     = issue_en_i & ~full_o & ~stall_i & ~flush_i;
   assign ex_valid_o = (|ready) & ~stall_i & ~flush_i;
   assign fire       = ex_valid_o & ex_ready_i;

   // lowest-index free slot; only current busy bits count, so a slot being
   // dispatched this cycle is not reused until the next one
   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (!busy_q[i] && !free_found) begin
            free_idx   = IW'(i);
            free_found = 1'b1;
         end
      end
   end

`ifdef RS_AGE_SELECT_EN
   // older_q[j][i] = 1 means entry j was issued before entry i
   logic [RS_DEPTH-1:0][RS_DEPTH-1:0] older_q, older_d;
   logic [RS_DEPTH-1:0]               oldest;

   // a new entry is younger than everything already present
   always_comb begin
      older_d = older_q;
      if (accept) begin
         for (int j = 0; j < RS_DEPTH; j++) begin
            older_d[free_idx][j] = 1'b0;
            older_d[j][free_idx] = (IW'(j) != free_idx);
         end
      end
   end

   // age matrix register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) older_q <= '0;
      else      older_q <= older_d;
   end

   // a ready entry is oldest when no other ready entry is older than it
   always_comb begin
      oldest    = '0;
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         oldest[i] = ready[i];
         for (int j = 0; j < RS_DEPTH; j++)
            if (j != i && ready[j] && older_q[j][i]) oldest[i] = 1'b0;
         if (oldest[i] && !sel_found) begin
            sel_idx   = IW'(i);
            sel_found = 1'b1;
         end
      end
   end
`else
   // fixed priority: lowest-index ready entry wins
   always_comb begin
      sel_idx   = '0;
      sel_found = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (ready[i] && !sel_found) begin
            sel_idx   = IW'(i);
            sel_found = 1'b1;
         end
      end
   end
`endif

   // execute outputs are zero whenever nothing is offered
   always_comb begin
      ex_op_o  = '0;
      ex_a_o   = '0;
      ex_b_o   = '0;
      ex_tag_o = '0;
      if (ex_valid_o) begin
         ex_op_o  = op_q[sel_idx];
         ex_a_o   = v1_q[sel_idx];
         ex_b_o   = v2_q[sel_idx];
         ex_tag_o = dest_q[sel_idx];
      end
   end

   // entry next state: flush wins, stall freezes, else wakeup+dispatch+issue
   always_comb begin
      busy_d = busy_q; r1_d = r1_q; r2_d = r2_q; op_d = op_q;
      v1_d = v1_q; v2_d = v2_q; q1_d = q1_q; q2_d = q2_q; dest_d = dest_q;
      if (flush_i) begin
         busy_d = '0;
      end else if (!stall_i) begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (busy_q[i] && cdb_valid_i) begin
               if (!r1_q[i] && q1_q[i] == cdb_tag_i) begin
                  v1_d[i] = cdb_value_i;
                  r1_d[i] = 1'b1;
               end
               if (!r2_q[i] && q2_q[i] == cdb_tag_i) begin
                  v2_d[i] = cdb_value_i;
                  r2_d[i] = 1'b1;
               end
            end
         end
         if (fire) busy_d[sel_idx] = 1'b0;
         if (accept) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = issue_op_i;
            dest_d[free_idx] = dest_tag_i;
            q1_d[free_idx]   = rs1_tag_i;
            q2_d[free_idx]   = rs2_tag_i;
            if (rs1_valid_i) begin
               v1_d[free_idx] = rs1_value_i; r1_d[free_idx] = 1'b1;
            end else if (cdb_valid_i && cdb_tag_i == rs1_tag_i) begin
               v1_d[free_idx] = cdb_value_i; r1_d[free_idx] = 1'b1;
            end else begin
               r1_d[free_idx] = 1'b0;
            end
            if (rs2_valid_i) begin
               v2_d[free_idx] = rs2_value_i; r2_d[free_idx] = 1'b1;
            end else if (cdb_valid_i && cdb_tag_i == rs2_tag_i) begin
               v2_d[free_idx] = cdb_value_i; r2_d[free_idx] = 1'b1;
            end else begin
               r2_d[free_idx] = 1'b0;
            end
         end
      end
   end

   // entry state registers; reset only needs to clear busy and ready flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0; r1_q <= '0; r2_q <= '0; op_q <= '0;
         v1_q <= '0; v2_q <= '0; q1_q <= '0; q2_q <= '0; dest_q <= '0;
      end else begin
         busy_q <= busy_d; r1_q <= r1_d; r2_q <= r2_d; op_q <= op_d;
         v1_q <= v1_d; v2_q <= v2_d; q1_q <= q1_d; q2_q <= q2_d; dest_q <= dest_d;
      end
   end
endmodule
